// File: rtl/aes_scoreboard_if.sv
// Expected/actual result channels between the AES bench components and the scoreboard.
// exp: a transfer happens on a rising clk edge where exp_valid && exp_ready; act has no ready
// and is consumed in every cycle where act_valid is high.
interface aes_scoreboard_if #(
    parameter int DW = 128,
    parameter int TW = 4
);
    logic          exp_valid;
    logic          exp_ready;
    logic [DW-1:0] exp_data;
    logic [TW-1:0] exp_tag;
    logic          act_valid;
    logic [DW-1:0] act_data;
    logic [TW-1:0] act_tag;
    logic [DW-1:0] cmp_mask;

    modport master (
        output exp_valid, exp_data, exp_tag, act_valid, act_data, act_tag, cmp_mask,
        input  exp_ready
    );

    modport slave (
        input  exp_valid, exp_data, exp_tag, act_valid, act_data, act_tag, cmp_mask,
        output exp_ready
    );
endinterface

// File: rtl/aes_scoreboard.sv
// In-order scoreboard: queues expected results, compares each actual result against the head,
// and keeps saturating pass/fail counters, first-mismatch capture, underflow and timeout flags.
module aes_scoreboard #(
    parameter int DW      = 128,
    parameter int TW      = 4,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024,
    parameter int CW      = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    aes_scoreboard_if.slave          sb,
    output logic [CW-1:0]            pass_cnt,
    output logic [CW-1:0]            fail_cnt,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     fail_seen,
    output logic [DW-1:0]            fail_exp,
    output logic [DW-1:0]            fail_act,
    output logic [CW-1:0]            fail_idx,
    output logic                     underflow,
    output logic                     timeout,
    output logic                     idle
);
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(TIMEOUT);

    logic [DW-1:0]  mem_data [DEPTH];
    logic [TW-1:0]  mem_tag  [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [PW-1:0]  count;
    logic [WCW-1:0] wait_cnt;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          match;
    logic [DW-1:0] head_data;
    logic [TW-1:0] head_tag;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    assign full      = (count == PW'(DEPTH));
    assign empty     = (count == '0);
    // A pop in the same cycle does not free a slot: ready looks at full only.
    assign push      = sb.exp_valid && !full;
    assign pop       = sb.act_valid && !empty;
    assign head_data = mem_data[rd_ptr];
    assign head_tag  = mem_tag[rd_ptr];
    assign match     = (((sb.act_data ^ head_data) & sb.cmp_mask) == '0) && (sb.act_tag == head_tag);

    assign sb.exp_ready = !full;
    assign pending      = count;
    assign idle         = empty && !fail_seen && !underflow && !timeout;

    always_ff @(posedge clk) begin
        if (push && rst_n && !clear) begin
            mem_data[wr_ptr] <= sb.exp_data;
            mem_tag[wr_ptr]  <= sb.exp_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wait_cnt  <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            fail_seen <= 1'b0;
            fail_exp  <= '0;
            fail_act  <= '0;
            fail_idx  <= '0;
            underflow <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);

            case ({push, pop})
                2'b10:   count <= count + PW'(1);
                2'b01:   count <= count - PW'(1);
                default: count <= count;
            endcase

            if (pop) begin
                if (match) begin
                    pass_cnt <= sat_inc(pass_cnt);
                end else begin
                    fail_cnt <= sat_inc(fail_cnt);
                    if (!fail_seen) begin
                        fail_seen <= 1'b1;
                        fail_exp  <= head_data;
                        fail_act  <= sb.act_data;
                        fail_idx  <= pass_cnt + fail_cnt;
                    end
                end
            end

            if (sb.act_valid && empty) underflow <= 1'b1;

            // wait_cnt parks at TIMEOUT; the flag is sticky so further counting is pointless.
            if (pop || empty)
                wait_cnt <= '0;
            else if (wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + WCW'(1);

            if ((TIMEOUT != 0) && !empty && (wait_cnt == WAIT_MAX)) timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_aes_scoreboard.sv
// Bench for aes_scoreboard: table of single compares plus hand sequences for capture,
// full/wrap, underflow, timeout, clear and reset.
module tb_aes_scoreboard;
    localparam int DW = 128;
    localparam int TW = 4;
    localparam int DEPTH = 8;
    localparam int TIMEOUT = 16;
    localparam int CW = 32;
    localparam logic [127:0] ALL1 = {128{1'b1}};
    localparam logic [127:0] FIPS = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    logic [CW-1:0] pass_cnt, fail_cnt, fail_idx;
    logic [$clog2(DEPTH):0] pending;
    logic fail_seen, underflow, timeout, idle;
    logic [DW-1:0] fail_exp, fail_act;

    aes_scoreboard_if #(.DW(DW), .TW(TW)) sb ();

    aes_scoreboard #(.DW(DW), .TW(TW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .sb(sb),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .pending(pending),
        .fail_seen(fail_seen), .fail_exp(fail_exp), .fail_act(fail_act),
        .fail_idx(fail_idx), .underflow(underflow), .timeout(timeout), .idle(idle)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [127:0] e_data;
        logic [3:0]   e_tag;
        logic [127:0] a_data;
        logic [3:0]   a_tag;
        logic [127:0] mask;
        logic         match;
    } vec_t;

    vec_t vecs[7];

    int checks = 0;
    int failures = 0;

    logic [127:0] exp_q[$];
    logic [3:0]   tag_q[$];
    int           m_pass, m_fail, m_fail_idx;
    logic         m_fail_seen, m_under, m_to;
    logic [127:0] m_fail_exp, m_fail_act;

    function automatic logic [127:0] gen(input int i);
        return {4{(32'(i) * 32'h9e3779b9) ^ 32'h5a5a0000}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        tag_q.delete();
        m_pass = 0; m_fail = 0; m_fail_idx = 0;
        m_fail_seen = 0; m_under = 0; m_to = 0;
        m_fail_exp = '0; m_fail_act = '0;
    endtask

    task automatic set_idle();
        sb.exp_valid = 0; sb.exp_data = '0; sb.exp_tag = '0;
        sb.act_valid = 0; sb.act_data = '0; sb.act_tag = '0;
        sb.cmp_mask = ALL1;
    endtask

    task automatic model_act(input logic [127:0] d, input logic m);
        logic [127:0] h;
        logic [3:0] t;
        if (exp_q.size() == 0) begin
            m_under = 1;
        end else begin
            h = exp_q.pop_front();
            t = tag_q.pop_front();
            if (m) begin
                m_pass++;
            end else begin
                if (!m_fail_seen) begin
                    m_fail_seen = 1;
                    m_fail_exp = h;
                    m_fail_act = d;
                    m_fail_idx = m_pass + m_fail;
                end
                m_fail++;
            end
        end
    endtask

    // One clock with optional push and optional actual; m is the bench's own verdict.
    task automatic cycle(input logic ev, input logic [127:0] ed, input logic [3:0] et,
                         input logic av, input logic [127:0] ad, input logic [3:0] at,
                         input logic [127:0] mask, input logic m);
        bit was_full;
        was_full = (exp_q.size() >= DEPTH);
        sb.exp_valid = ev; sb.exp_data = ed; sb.exp_tag = et;
        sb.act_valid = av; sb.act_data = ad; sb.act_tag = at;
        sb.cmp_mask = mask;
        tick();
        set_idle();
        if (av) model_act(ad, m);
        if (ev && !was_full) begin
            exp_q.push_back(ed);
            tag_q.push_back(et);
        end
    endtask

    task automatic push(input logic [127:0] d, input logic [3:0] t);
        cycle(1'b1, d, t, 1'b0, '0, '0, ALL1, 1'b1);
    endtask

    task automatic act(input logic [127:0] d, input logic [3:0] t, input logic m);
        cycle(1'b0, '0, '0, 1'b1, d, t, ALL1, m);
    endtask

    task automatic check_all(input string name);
        logic want_idle;
        want_idle = (exp_q.size() == 0) && !m_fail_seen && !m_under && !m_to;
        chk({name, ".pass_cnt"},  pass_cnt,  128'(m_pass));
        chk({name, ".fail_cnt"},  fail_cnt,  128'(m_fail));
        chk({name, ".pending"},   pending,   128'(exp_q.size()));
        chk({name, ".exp_ready"}, sb.exp_ready, (exp_q.size() < DEPTH) ? 128'd1 : 128'd0);
        chk({name, ".fail_seen"}, fail_seen, 128'(m_fail_seen));
        chk({name, ".fail_exp"},  fail_exp,  m_fail_exp);
        chk({name, ".fail_act"},  fail_act,  m_fail_act);
        chk({name, ".fail_idx"},  fail_idx,  128'(m_fail_idx));
        chk({name, ".underflow"}, underflow, 128'(m_under));
        chk({name, ".timeout"},   timeout,   128'(m_to));
        chk({name, ".idle"},      idle,      128'(want_idle));
    endtask

    // Clear cycle also offers a push and an actual, which must be discarded.
    task automatic do_clear();
        clear = 1; sb.exp_valid = 1; sb.exp_data = gen(77); sb.act_valid = 1;
        tick();
        clear = 0;
        set_idle();
        model_reset();
    endtask

    task automatic do_reset();
        rst_n = 0; sb.exp_valid = 1; sb.exp_data = gen(78); sb.act_valid = 1;
        tick();
        rst_n = 1;
        set_idle();
        model_reset();
    endtask

    initial begin
        logic [127:0] seq [4];
        int n;

        vecs[0] = '{FIPS, 4'h0, FIPS, 4'h0, ALL1, 1'b1};
        vecs[1] = '{FIPS, 4'h1, FIPS ^ 128'h1, 4'h1, ALL1, 1'b0};
        vecs[2] = '{gen(5), 4'h2, gen(5) ^ 128'h00000000_00000000_dead_beef_0123_4567, 4'h2,
                    128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000, 1'b1};
        vecs[3] = '{gen(6), 4'h3, gen(6) ^ {1'b1, 127'h0}, 4'h3,
                    128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000, 1'b0};
        vecs[4] = '{gen(7), 4'h4, ~gen(7), 4'h4, 128'h0, 1'b1};
        vecs[5] = '{gen(8), 4'h5, gen(8), 4'h6, 128'h0, 1'b0};
        vecs[6] = '{gen(9), 4'hF, gen(9), 4'hF, ALL1, 1'b1};

        model_reset();
        set_idle();
        clear = 0;
        rst_n = 0;
        repeat (3) tick();
        rst_n = 1;
        check_all("reset");

        // Sequential match.
        seq[0] = FIPS; seq[1] = gen(1); seq[2] = gen(2); seq[3] = gen(3);
        for (int i = 0; i < 4; i++) push(seq[i], 4'(i));
        chk("seq.pending4", pending, 128'd4);
        for (int i = 0; i < 4; i++) act(seq[i], 4'(i), 1'b1);
        check_all("seq");
        chk("seq.pass4", pass_cnt, 128'd4);

        // Mismatch capture.
        do_clear();
        check_all("clear1");
        for (int i = 0; i < 3; i++) push(gen(10 + i), 4'(i));
        act(gen(10), 4'h0, 1'b1);
        act(gen(11) ^ 128'h1, 4'h1, 1'b0);
        act(gen(12), 4'h9, 1'b0);
        check_all("mism");
        chk("mism.fail_act_flipped", fail_act, gen(11) ^ 128'h1);
        chk("mism.fail_idx1", fail_idx, 128'd1);

        // Table-driven single compares with various masks.
        do_clear();
        for (int i = 0; i < 7; i++) begin
            push(vecs[i].e_data, vecs[i].e_tag);
            cycle(1'b0, '0, '0, 1'b1, vecs[i].a_data, vecs[i].a_tag, vecs[i].mask, vecs[i].match);
            check_all($sformatf("vec%0d", i));
        end

        // Full, blocked push with pop, then streaming across pointer wrap.
        do_clear();
        for (int i = 0; i < DEPTH; i++) push(gen(100 + i), 4'(i));
        chk("full.exp_ready", sb.exp_ready, 128'd0);
        chk("full.pending", pending, 128'd8);
        cycle(1'b1, gen(108), 4'(8), 1'b1, exp_q[0], tag_q[0], ALL1, 1'b1);
        chk("full.pop.pending", pending, 128'd7);
        chk("full.pop.exp_ready", sb.exp_ready, 128'd1);
        n = 8;
        while (n < 3 * DEPTH) begin
            cycle(1'b1, gen(100 + n), 4'(n), 1'b1, exp_q[0], tag_q[0], ALL1, 1'b1);
            n++;
        end
        chk("wrap.pending7", pending, 128'd7);
        while (exp_q.size() > 0) act(exp_q[0], tag_q[0], 1'b1);
        check_all("wrap");
        chk("wrap.pass24", pass_cnt, 128'd24);

        // Underflow with a same-cycle push.
        do_clear();
        cycle(1'b1, gen(200), 4'h3, 1'b1, gen(201), 4'h3, ALL1, 1'b1);
        check_all("under");
        chk("under.flag", underflow, 128'd1);
        chk("under.pending", pending, 128'd1);

        // Timeout: head entry left waiting.
        do_clear();
        push(gen(300), 4'h1);
        repeat (15) tick();
        chk("to.early", timeout, 128'd0);
        repeat (3) tick();
        m_to = 1;
        check_all("to");
        chk("to.pending", pending, 128'd1);
        do_clear();
        check_all("to.clear");

        // Reset mid-stream, then confirm normal operation resumes.
        for (int i = 0; i < 3; i++) push(gen(400 + i), 4'(i));
        act(gen(400) ^ 128'h10, 4'h0, 1'b0);
        do_reset();
        check_all("rst");
        push(gen(500), 4'h7);
        act(gen(500), 4'h7, 1'b1);
        check_all("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
